// File: rtl/axis_bram_stream_reader_pkg.sv
// axis_bram_stream_reader_pkg: shared FSM encoding and bit-reverse helper
package axis_bram_stream_reader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        RUN   = 3'b010,
        DRAIN = 3'b100
    } state_t;

    // Reverses a 32-bit word; callers shift right to reverse narrower indices.
    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

endpackage

// File: rtl/axis_bram_stream_reader_if.sv
// axis_bram_stream_reader_if: AXI-stream bundle with master/slave views
interface axis_bram_stream_reader_if #(
    parameter int SAMPLE_WIDTH = 16
);
    logic                        tvalid;
    logic                        tready;
    logic [2*SAMPLE_WIDTH-1:0]   tdata;
    logic [SAMPLE_WIDTH/4-1:0]   tkeep;
    logic                        tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_bram_stream_reader_fifo.sv
// axis_bram_stream_reader_fifo: synchronous first-word-fall-through FIFO with occupancy count
module axis_bram_stream_reader_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr, rptr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign rd_data = mem[rptr];

    // Storage array, no reset needed since count gates its visibility
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= wr_data;
    end

    // Pointers and occupancy; flush empties the FIFO in one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) wptr <= nxt(wptr);
            if (rd_en) rptr <= nxt(rptr);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(wr_en && !rd_en && count == CW'(DEPTH)));

endmodule

// File: rtl/axis_bram_stream_reader.sv
// axis_bram_stream_reader: credit-based BRAM frame reader with scaling, saturation and AXI-stream output
module axis_bram_stream_reader
    import axis_bram_stream_reader_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int FIELD_WIDTH  = 24,
    parameter int SAMPLE_WIDTH = 16,
    parameter int RD_LATENCY   = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          go,
    input  logic                          abort,
    input  logic [ADDR_WIDTH-1:0]         cfg_base,
    input  logic [ADDR_WIDTH-1:0]         cfg_len,
    input  logic                          cfg_bitrev,
    input  logic                          cfg_cplx,
    input  logic [$clog2(FIELD_WIDTH)-1:0] cfg_shift,
    output logic                          busy,
    output logic                          done,
    output logic                          sat_flag,
    output logic [ADDR_WIDTH-1:0]         mem_raddr,
    output logic                          mem_clken,
    input  logic [2*FIELD_WIDTH-1:0]      mem_rdata,
    axis_bram_stream_reader_if.master     m_axis
);

    localparam int SHW = $clog2(FIELD_WIDTH);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int CW  = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
    localparam int DW  = 2 * SAMPLE_WIDTH + 1;
    localparam int KH  = SAMPLE_WIDTH / 8;

    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   idx, base_r, len_m1_r, rev;
    logic                    bitrev_r, cplx_r;
    logic [SHW-1:0]          shift_r;
    logic [RD_LATENCY-1:0]   tag_v, tag_l;
    logic [FCW-1:0]          fifo_count;
    logic [CW-1:0]           inflight;
    logic                    start, issue, last_issue, pop, fin, wr;
    logic [SAMPLE_WIDTH-1:0] re_s, im_s;
    logic                    re_sat, im_sat;
    logic [DW-1:0]           wr_data, rd_data;

    // Returns {saturated, sample}: arithmetic shift then clamp to the signed sample range
    function automatic logic [SAMPLE_WIDTH:0] scale(input logic [FIELD_WIDTH-1:0] x, input logic [SHW-1:0] sh);
        logic signed [FIELD_WIDTH-1:0] s;
        logic fits;
        s = $signed(x) >>> sh;
        fits = &s[FIELD_WIDTH-1:SAMPLE_WIDTH-1] || ~|s[FIELD_WIDTH-1:SAMPLE_WIDTH-1];
        return fits ? {1'b0, s[SAMPLE_WIDTH-1:0]}
                    : {1'b1, s[FIELD_WIDTH-1], {(SAMPLE_WIDTH-1){~s[FIELD_WIDTH-1]}}};
    endfunction

    assign start      = state == IDLE && go && !abort;
    assign issue      = state == RUN && !abort && inflight + CW'(fifo_count) < CW'(FIFO_DEPTH);
    assign last_issue = issue && idx == len_m1_r;
    assign pop        = m_axis.tvalid && m_axis.tready;
    assign fin        = state == DRAIN && !abort && inflight == '0 && pop && m_axis.tlast;
    assign wr         = tag_v[RD_LATENCY-1] && !abort;
    assign rev        = ADDR_WIDTH'(bitrev32(32'(idx)) >> (32 - ADDR_WIDTH));

    assign {re_sat, re_s} = scale(mem_rdata[FIELD_WIDTH-1:0], shift_r);
    assign {im_sat, im_s} = scale(mem_rdata[2*FIELD_WIDTH-1:FIELD_WIDTH], shift_r);
    assign wr_data        = {tag_l[RD_LATENCY-1], cplx_r ? im_s : {SAMPLE_WIDTH{1'b0}}, re_s};

    // Reads still travelling through the BRAM pipeline
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(tag_v[i]);
    end

    // Next state and issue-side outputs; abort overrides everything
    always_comb begin
        state_nx  = abort ? IDLE : start ? RUN : last_issue ? DRAIN : fin ? IDLE : state;
        busy      = state != IDLE;
        mem_clken = issue;
        mem_raddr = issue ? base_r + (bitrev_r ? rev : idx) : '0;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Frame configuration, issue index, latency tags, done pulse and sticky saturation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx      <= '0;
            base_r   <= '0;
            len_m1_r <= '0;
            bitrev_r <= 1'b0;
            cplx_r   <= 1'b0;
            shift_r  <= '0;
            tag_v    <= '0;
            tag_l    <= '0;
            done     <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            done  <= fin;
            tag_v <= abort ? '0 : RD_LATENCY'({tag_v, issue});
            tag_l <= RD_LATENCY'({tag_l, last_issue});
            if (start) begin
                idx      <= '0;
                base_r   <= cfg_base;
                len_m1_r <= cfg_len - 1'b1;
                bitrev_r <= cfg_bitrev;
                cplx_r   <= cfg_cplx;
                shift_r  <= cfg_shift;
                sat_flag <= 1'b0;
            end else if (issue) begin
                idx <= idx + 1'b1;
            end
            if (wr && (re_sat || (cplx_r && im_sat))) sat_flag <= 1'b1;
        end
    end

    axis_bram_stream_reader_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (abort),
        .wr_en   (wr),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .count   (fifo_count)
    );

    assign m_axis.tvalid = fifo_count != '0;
    assign m_axis.tdata  = rd_data[DW-2:0];
    assign m_axis.tlast  = m_axis.tvalid && rd_data[DW-1];
    assign m_axis.tkeep  = cplx_r ? {(2*KH){1'b1}} : {{KH{1'b0}}, {KH{1'b1}}};

endmodule

// File: tb/tb_axis_bram_stream_reader.sv
// tb_axis_bram_stream_reader: scoreboard and vector-table bench for the BRAM stream reader
module tb_axis_bram_stream_reader;

    localparam int FD = 4;

    logic        clk = 1'b0, reset = 1'b1, go = 1'b0, abort = 1'b0;
    logic [11:0] cfg_base = '0, cfg_len = '0;
    logic        cfg_bitrev = 1'b0, cfg_cplx = 1'b0;
    logic [4:0]  cfg_shift = '0;
    logic        busy, done, sat_flag, mem_clken;
    logic [11:0] mem_raddr;
    logic [47:0] mem_rdata, r1, r2;
    logic [47:0] mem [4096];

    axis_bram_stream_reader_if #(.SAMPLE_WIDTH(16)) m_axis ();

    axis_bram_stream_reader dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .abort      (abort),
        .cfg_base   (cfg_base),
        .cfg_len    (cfg_len),
        .cfg_bitrev (cfg_bitrev),
        .cfg_cplx   (cfg_cplx),
        .cfg_shift  (cfg_shift),
        .busy       (busy),
        .done       (done),
        .sat_flag   (sat_flag),
        .mem_raddr  (mem_raddr),
        .mem_clken  (mem_clken),
        .mem_rdata  (mem_rdata),
        .m_axis     (m_axis)
    );

    always #5 clk = ~clk;

    // Two-cycle BRAM read model
    always @(posedge clk) begin
        r1 <= mem[mem_raddr];
        r2 <= r1;
    end
    assign mem_rdata = r2;

    typedef struct {
        logic [31:0] data;
        logic        last;
        bit          sat;
    } beat_t;

    typedef struct {
        logic [23:0] re;
        logic [23:0] im;
        int          sh;
        bit          cx;
        logic [31:0] exp_data;
        logic [3:0]  exp_keep;
        bit          exp_sat;
    } vec_t;

    beat_t       exp_q[$];
    logic [11:0] addr_q[$];
    int          tests = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] rev12(input logic [11:0] x);
        logic [11:0] r;
        for (int i = 0; i < 12; i++) r[11-i] = x[i];
        return r;
    endfunction

    function automatic logic [15:0] sc(input logic [23:0] f, input int sh, inout bit sat);
        int v;
        v = int'($signed(f)) >>> sh;
        if (v > 32767) begin
            v = 32767;
            sat = 1;
        end else if (v < -32768) begin
            v = -32768;
            sat = 1;
        end
        return v[15:0];
    endfunction

    task automatic run_frame(input logic [11:0] base, input logic [11:0] len, input bit br, input bit cx,
                             input int sh, input int pct, input int cut_beat, input bit cut_rst,
                             output logic [31:0] ld, output logic [3:0] lk);
        int          n, cyc, beats, issued, lat;
        bit          s, fin, done_next, stall, sat_exp, sat_seen;
        logic [31:0] pd;
        logic        pl;
        logic [11:0] a;
        logic [15:0] re, im;
        beat_t       b;
        n = (len == 0) ? 4096 : int'(len);
        exp_q.delete();
        addr_q.delete();
        sat_exp = 0;
        sat_seen = 0;
        ld = '0;
        lk = '0;
        for (int i = 0; i < n; i++) begin
            a = base + (br ? rev12(12'(i)) : 12'(i));
            addr_q.push_back(a);
            s = 0;
            re = sc(mem[a][23:0], sh, s);
            im = 16'h0;
            if (cx) im = sc(mem[a][47:24], sh, s);
            sat_exp |= s;
            b.data = {im, re};
            b.last = (i == n - 1);
            b.sat = s;
            exp_q.push_back(b);
        end
        @(negedge clk);
        cfg_base = base;
        cfg_len = len;
        cfg_bitrev = br;
        cfg_cplx = cx;
        cfg_shift = 5'(sh);
        go = 1'b1;
        cyc = 0;
        beats = 0;
        issued = 0;
        lat = -1;
        fin = 0;
        done_next = 0;
        stall = 0;
        pd = '0;
        pl = 1'b0;
        while (!fin && cyc < 8 * n + 64) begin
            @(negedge clk);
            cyc++;
            go = (cyc == 12) && busy;
            if (cyc == 1 || cyc == 12) begin
                cfg_base = 12'($urandom);
                cfg_len = 12'($urandom);
                cfg_bitrev = ~br;
                cfg_cplx = ~cx;
                cfg_shift = 5'($urandom_range(15));
            end
            if (done_next) begin
                chk("done pulse", 32'(done), 32'd1);
                chk("busy after done", 32'(busy), 32'd0);
                fin = 1;
            end else begin
                chk("no early done", 32'(done), 32'd0);
            end
            if (mem_clken) begin
                issued++;
                if (addr_q.size() == 0) chk("extra read issued", 32'(mem_raddr), 32'hFFFF_FFFF);
                else chk("read address", 32'(mem_raddr), 32'(addr_q.pop_front()));
            end
            chk("occupancy bound", 32'(issued - beats <= FD), 32'd1);
            if (m_axis.tvalid && lat < 0) begin
                lat = cyc;
                chk("first valid latency", 32'(cyc), 32'd4);
            end
            if (stall) begin
                chk("hold valid", 32'(m_axis.tvalid), 32'd1);
                chk("hold data", m_axis.tdata, pd);
                chk("hold last", 32'(m_axis.tlast), 32'(pl));
            end
            if (pct == 100 && lat > 0 && beats < n) chk("no bubble", 32'(m_axis.tvalid), 32'd1);
            if (cut_beat >= 0 && beats == cut_beat) begin
                if (cut_rst && sat_seen) chk("sat before reset", 32'(sat_flag), 32'd1);
                m_axis.tready = 1'b0;
                if (cut_rst) reset = 1'b1;
                else abort = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                abort = 1'b0;
                chk("cut tvalid", 32'(m_axis.tvalid), 32'd0);
                chk("cut busy", 32'(busy), 32'd0);
                if (cut_rst) chk("reset clears sat", 32'(sat_flag), 32'd0);
                m_axis.tready = 1'b1;
                repeat (6) begin
                    @(negedge clk);
                    chk("cut no done", 32'(done), 32'd0);
                    chk("cut idle valid", 32'(m_axis.tvalid), 32'd0);
                    chk("cut no read", 32'(mem_clken), 32'd0);
                end
                return;
            end
            m_axis.tready = ($urandom_range(99) < pct);
            if (m_axis.tvalid && m_axis.tready) begin
                if (exp_q.size() == 0) begin
                    chk("extra beat", m_axis.tdata, 32'hDEAD_BEEF);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat data", m_axis.tdata, b.data);
                    chk("beat last", 32'(m_axis.tlast), 32'(b.last));
                    chk("beat keep", 32'(m_axis.tkeep), cx ? 32'hF : 32'h3);
                    sat_seen |= b.sat;
                    done_next = b.last;
                end
                ld = m_axis.tdata;
                lk = m_axis.tkeep;
                beats++;
            end
            stall = m_axis.tvalid && !m_axis.tready;
            pd = m_axis.tdata;
            pl = m_axis.tlast;
        end
        if (!fin) begin
            tests++;
            fails++;
            $display("FAIL frame timeout: beats %0d of %0d", beats, n);
        end
        chk("all beats delivered", 32'(exp_q.size()), 32'd0);
        chk("all reads issued", 32'(addr_q.size()), 32'd0);
        chk("frame sat_flag", 32'(sat_flag), 32'(sat_exp));
        repeat (3) begin
            @(negedge clk);
            chk("idle after frame", 32'(m_axis.tvalid), 32'd0);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[9];
        logic [31:0] ld;
        logic [3:0]  lk;
        vt[0] = '{24'h7FFFFF, 24'h000120, 4,  1'b1, 32'h0012_7FFF, 4'hF, 1'b1};
        vt[1] = '{24'h000120, 24'hFFFFF0, 4,  1'b1, 32'hFFFF_0012, 4'hF, 1'b0};
        vt[2] = '{24'hFFFFF0, 24'h000000, 4,  1'b0, 32'h0000_FFFF, 4'h3, 1'b0};
        vt[3] = '{24'h800000, 24'h000000, 0,  1'b1, 32'h0000_8000, 4'hF, 1'b1};
        vt[4] = '{24'hFF8000, 24'h007FFF, 0,  1'b1, 32'h7FFF_8000, 4'hF, 1'b0};
        vt[5] = '{24'h008000, 24'hFF0000, 1,  1'b1, 32'h8000_4000, 4'hF, 1'b0};
        vt[6] = '{24'h800000, 24'h7FFFFF, 23, 1'b1, 32'h0000_FFFF, 4'hF, 1'b0};
        vt[7] = '{24'h123456, 24'h555555, 8,  1'b0, 32'h0000_1234, 4'h3, 1'b0};
        vt[8] = '{24'hFEDCBA, 24'h000000, 12, 1'b1, 32'h0000_FFED, 4'hF, 1'b0};
        m_axis.tready = 1'b0;
        for (int a = 0; a < 4096; a++) mem[a] = {24'(-a), 24'(a)};

        @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset sat_flag", 32'(sat_flag), 32'd0);
        chk("reset mem_raddr", 32'(mem_raddr), 32'd0);
        chk("reset mem_clken", 32'(mem_clken), 32'd0);
        chk("reset tvalid", 32'(m_axis.tvalid), 32'd0);
        chk("reset tlast", 32'(m_axis.tlast), 32'd0);
        reset = 1'b0;

        run_frame(12'd0, 12'd0, 1'b0, 1'b1, 0, 100, -1, 1'b0, ld, lk);
        chk("full frame last data", ld, 32'hF001_0FFF);
        chk("full frame keep", 32'(lk), 32'hF);

        run_frame(12'd0, 12'd0, 1'b1, 1'b1, 0, 100, -1, 1'b0, ld, lk);
        chk("bitrev last data", ld, 32'hF001_0FFF);

        run_frame(12'd4090, 12'd10, 1'b0, 1'b1, 0, 100, -1, 1'b0, ld, lk);
        chk("wrap last data", ld, 32'hFFFD_0003);

        run_frame(12'd200, 12'd64, 1'b0, 1'b1, 2, 50, -1, 1'b0, ld, lk);

        for (int i = 0; i < 9; i++) begin
            mem[100] = {vt[i].im, vt[i].re};
            run_frame(12'd100, 12'd1, 1'b0, vt[i].cx, vt[i].sh, 100, -1, 1'b0, ld, lk);
            chk("vec data", ld, vt[i].exp_data);
            chk("vec keep", 32'(lk), 32'(vt[i].exp_keep));
            chk("vec sat", 32'(sat_flag), 32'(vt[i].exp_sat));
        end

        run_frame(12'd500, 12'd100, 1'b0, 1'b1, 0, 100, 20, 1'b0, ld, lk);

        @(negedge clk);
        cfg_len = 12'd5;
        go = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        go = 1'b0;
        abort = 1'b0;
        chk("go+abort busy", 32'(busy), 32'd0);
        repeat (5) begin
            @(negedge clk);
            chk("go+abort no read", 32'(mem_clken), 32'd0);
            chk("go+abort no valid", 32'(m_axis.tvalid), 32'd0);
        end

        for (int a = 300; a < 400; a++) mem[a] = {24'h400000 + 24'(a), 24'hC00000 - 24'(a)};
        run_frame(12'd300, 12'd100, 1'b0, 1'b1, 0, 100, 50, 1'b1, ld, lk);
        run_frame(12'd7, 12'd3, 1'b0, 1'b1, 0, 100, -1, 1'b0, ld, lk);
        chk("post-cut last data", ld, 32'hFFF7_0009);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
